mem_access_unit: RTL and testbench

//  Consumer of the EXE->MEM data-cache request: memaddr, mem_en, mem_write, rs2_data, funct3.
//  - Turns one load/store per instruction into a valid/ready bus transaction.
//  - Generates byte strobes, shifts store data and aligns/extends load data.
//  - Stalls the pipeline via mem_ready until the access completes.
//  - Sits in the MEM stage between the EXE->MEM pipeline register and the d-cache/bus.

---
 rtl/mem_access_unit_pkg.sv | 52 +++++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit_lsu_align.sv | 37 +++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage access unit.
//   mem_state_e : access FSM states
//   F3_*        : RV64 load/store funct3 size/sign codes
//   mem_req_t   : captured copy of the MEM-stage request
//   size_mask   : byte-lane mask for an access size, before lane shifting
//   is_misaligned : natural-alignment test for an access size
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // addr is kept at the widest supported width; the top truncates.
  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

  // funct3[1:0] alone encodes the size; 3'b111 falls into the D slot.
  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off[1:0] != 2'b00);
      default: is_misaligned = (off != 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache / bus request-response channel.
// Handshake: a request transfers on the cycle where req_valid and req_ready are
// both high; once req_valid rises the master holds req_write/addr/wdata/wstrb
// stable until that transfer (or until the master withdraws it on a flush).
// Each accepted load returns exactly one resp_valid pulse carrying resp_rdata;
// stores get no response.
//   master : the access unit (drives request, receives response)
//   slave  : the cache / bus model
interface mem_access_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              resp_valid;
  logic [63:0]       resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: purely combinational lane alignment for one 8-byte bus word.
//   funct3   in  access size/sign code
//   offset   in  byte offset addr[2:0]
//   st_data  in  unshifted store data
//   ld_raw   in  raw 8-byte word from the bus
//   st_wdata out store data moved to its byte lane
//   st_wstrb out byte enables, truncated at the word boundary
//   ld_data  out load value moved to bit 0 and sign/zero extended
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] st_data,
  input  logic [63:0] ld_raw,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wstrb,
  output logic [63:0] ld_data
);
  logic [63:0] shifted;

  always_comb begin
    // An 8-bit shift drops lanes past the word end, giving truncated strobes.
    st_wstrb = size_mask(funct3) << offset;
    st_wdata = st_data << {offset, 3'b000};
    shifted  = ld_raw >> {offset, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   ld_data = {56'd0, shifted[7:0]};
      F3_HU:   ld_data = {48'd0, shifted[15:0]};
      F3_WU:   ld_data = {32'd0, shifted[31:0]};
      default: ld_data = shifted;  // D and 3'b111
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Turns the held EXE->MEM
// request into one bus transaction and stalls the pipeline until it completes.
//   clk, rst (async, active-low), flush
//   req_valid/req_write/req_addr/req_wdata/req_funct3 : MEM-stage request
//   mem_ready    : MEM stage may advance this cycle
//   load_data    : aligned, extended load result (valid with mem_ready on a load)
//   bus          : request/response channel (master side)
//   exc_misalign/exc_store : misalignment trap, present only with MEM_MISALIGN_TRAP_EN
//   state_dbg    : current FSM state
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W/D accesses
// instead of issuing them to the bus.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              mem_ready,
  output logic [XLEN-1:0]   load_data,
  mem_access_unit_if.master bus,
  output logic              exc_misalign,
  output logic              exc_store,
  output mem_state_e        state_dbg
);

  mem_state_e state_q, state_d;
  mem_req_t   req_q, req_d;
  logic [63:0] load_data_q, load_data_d;
  logic [63:0] st_wdata, ld_data;
  logic [7:0]  st_wstrb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`endif

  lsu_align u_align (
    .funct3   (req_q.funct3),
    .offset   (req_q.addr[2:0]),
    .st_data  (req_q.wdata),
    .ld_raw   (bus.resp_rdata),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    load_data_d = load_data_q;
    mem_ready   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d      = trap_q;
`endif
    case (state_q)
      IDLE: begin
        mem_ready = !req_valid;
        if (req_valid && !flush) begin
          req_d = '{write: req_write, addr: 64'(req_addr),
                    wdata: req_wdata, funct3: req_funct3};
          state_d = REQ;
`ifdef MEM_MISALIGN_TRAP_EN
          trap_d = is_misaligned(req_funct3, req_addr[2:0]);
          if (trap_d) state_d = DONE;
`endif
        end
      end
      REQ: begin
        // A flush racing the handshake cannot un-send the request: a load
        // accepted that cycle still owes a response, so it must drain.
        if (bus.req_ready) begin
          if (req_q.write) state_d = flush ? IDLE : DONE;
          else             state_d = flush ? DRAIN : RESP;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (bus.resp_valid) begin
          load_data_d = ld_data;
          state_d     = DONE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        mem_ready = 1'b1;
        if (bus.resp_valid) state_d = IDLE;
      end
      DONE: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      load_data_q <= load_data_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trap_q <= 1'b0;
    else      trap_q <= trap_d;
  end
  assign exc_misalign = (state_q == DONE) && trap_q;
  assign exc_store    = (state_q == DONE) && trap_q && req_q.write;
`else
  assign exc_misalign = 1'b0;
  assign exc_store    = 1'b0;
`endif

  assign bus.req_valid = (state_q == REQ);
  assign bus.req_write = req_q.write;
  assign bus.req_addr  = {req_q.addr[ADDR_W-1:3], 3'b000};
  assign bus.req_wdata = st_wdata;
  assign bus.req_wstrb = req_q.write ? st_wstrb : 8'h00;
  assign load_data     = load_data_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int ADDR_W = 64;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic [2:0]        req_funct3 = '0;
  logic              mem_ready;
  logic [63:0]       load_data;
  logic              exc_misalign, exc_store;
  mem_state_e        state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .mem_ready    (mem_ready),
    .load_data    (load_data),
    .bus          (bus.master),
    .exc_misalign (exc_misalign),
    .exc_store    (exc_store),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [2:0] f3);
    int bytes;
    logic [63:0] v, m;
    bytes = 1 << f3[1:0];
    v = raw >> (8 * off);
    if (bytes == 8) return v;
    m = (64'd1 << (8 * bytes)) - 64'd1;
    v = v & m;
    if (!f3[2] && v[8*bytes-1]) v = v | ~m;
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access from IDLE back to IDLE, checked at every cycle.
  task automatic do_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [2:0] f3, input int rdly, input int pdly,
                           input logic [63:0] rd, output logic [63:0] got_ld);
    logic [63:0] exp_addr, exp_wd, exp_ld, popped;
    logic [15:0] wide;
    logic [7:0]  exp_strb;
    logic [2:0]  off;
    int bytes;
    off      = addr[2:0];
    bytes    = 1 << f3[1:0];
    exp_addr = {addr[63:3], 3'b000};
    wide     = ((16'd1 << bytes) - 16'd1) << off;
    exp_strb = wr ? wide[7:0] : 8'h00;
    exp_wd   = wd << (8 * off);
    exp_ld   = ref_load(rd, off, f3);

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL idle_stall: mem_ready=%b want 0", mem_ready); end
    step();
    checks++;
    if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL req_launch: req_valid=%b want 1", bus.req_valid); end
    checks++;
    if (bus.req_addr !== exp_addr || bus.req_write !== wr)
      begin failures++; $display("FAIL req_addr: addr=%h wr=%b want %h %b", bus.req_addr, bus.req_write, exp_addr, wr); end
    checks++;
    if (bus.req_wstrb !== exp_strb)
      begin failures++; $display("FAIL req_wstrb: got %h want %h", bus.req_wstrb, exp_strb); end
    if (wr) begin
      checks++;
      if (bus.req_wdata !== exp_wd)
        begin failures++; $display("FAIL req_wdata: got %h want %h", bus.req_wdata, exp_wd); end
    end
    for (int i = 0; i < rdly; i++) begin
      step();
      checks++;
      if (bus.req_valid !== 1'b1 || bus.req_addr !== exp_addr || mem_ready !== 1'b0)
        begin failures++; $display("FAIL req_hold: valid=%b addr=%h ready=%b want 1 %h 0", bus.req_valid, bus.req_addr, mem_ready, exp_addr); end
    end
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    if (wr) begin
      checks++;
      if (mem_ready !== 1'b1) begin failures++; $display("FAIL store_done: mem_ready=%b want 1", mem_ready); end
    end else begin
      for (int i = 0; i < pdly; i++) begin
        checks++;
        if (mem_ready !== 1'b0 || bus.req_valid !== 1'b0)
          begin failures++; $display("FAIL resp_wait: ready=%b valid=%b want 0 0", mem_ready, bus.req_valid); end
        step();
      end
      bus.resp_valid = 1'b1; bus.resp_rdata = rd;
      exp_q.push_back(exp_ld);
      step();
      bus.resp_valid = 1'b0; bus.resp_rdata = {$urandom, $urandom};
      checks++;
      if (mem_ready !== 1'b1) begin failures++; $display("FAIL load_done: mem_ready=%b want 1", mem_ready); end
      popped = exp_q.pop_front();
      checks++;
      if (load_data !== popped) begin failures++; $display("FAIL load_data: got %h want %h", load_data, popped); end
    end
    got_ld = load_data;
    checks++;
    if (exc_misalign !== 1'b0 || exc_store !== 1'b0)
      begin failures++; $display("FAIL no_exc: exc=%b%b want 00", exc_misalign, exc_store); end
    req_valid = 1'b0;
    step();
    checks++;
    if (state_dbg !== IDLE || bus.req_valid !== 1'b0)
      begin failures++; $display("FAIL done_one_cycle: state=%0d valid=%b want IDLE 0", state_dbg, bus.req_valid); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b0;
    step();
    checks++;
    if (bus.req_valid !== 1'b0 || load_data !== 64'd0 || exc_misalign !== 1'b0 || exc_store !== 1'b0)
      begin failures++; $display("FAIL reset_outputs: valid=%b ld=%h exc=%b%b want 0 0 00", bus.req_valid, load_data, exc_misalign, exc_store); end
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_idle: got %b want 1", mem_ready); end
    req_valid = 1'b1; #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_req: got %b want 0", mem_ready); end
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
  endtask

  task automatic test_store();
    logic [63:0] ld;
    do_access(1'b1, 64'h1000, 64'h1122334455667788, F3_D, 0, 0, 64'd0, ld);
    do_access(1'b1, 64'h1003, 64'h00000000000000AB, F3_B, 0, 0, 64'd0, ld);
    do_access(1'b1, 64'h1006, 64'h000000000000BEEF, F3_H, 1, 0, 64'd0, ld);
    do_access(1'b1, 64'h1004, 64'h00000000CAFEF00D, F3_W, 2, 0, 64'd0, ld);
  endtask

  task automatic test_load_extend();
    logic [63:0] ld;
    do_access(1'b0, 64'h2006, 64'd0, F3_H, 0, 0, 64'h8001_0000_0000_0000, ld);
    checks++;
    if (ld !== 64'hFFFF_FFFF_FFFF_8001) begin failures++; $display("FAIL lh_sign: got %h want ffffffffffff8001", ld); end
    do_access(1'b0, 64'h2006, 64'd0, F3_HU, 0, 1, 64'h8001_0000_0000_0000, ld);
    checks++;
    if (ld !== 64'h0000_0000_0000_8001) begin failures++; $display("FAIL lhu_zero: got %h want 8001", ld); end
    do_access(1'b0, 64'h2001, 64'd0, F3_B, 0, 0, 64'h0000_0000_0000_9000, ld);
    do_access(1'b0, 64'h2001, 64'd0, F3_BU, 0, 0, 64'h0000_0000_0000_9000, ld);
    do_access(1'b0, 64'h2004, 64'd0, F3_W, 0, 0, 64'hF234_5678_0000_0000, ld);
    do_access(1'b0, 64'h2004, 64'd0, F3_WU, 0, 0, 64'hF234_5678_0000_0000, ld);
    do_access(1'b0, 64'h2008, 64'd0, 3'b111, 0, 0, 64'h8877_6655_4433_2211, ld);
  endtask

  task automatic test_stall();
    logic [63:0] ld;
    do_access(1'b0, 64'h2010, 64'd0, F3_W, 5, 2, 64'h0000_0000_8765_4321, ld);
  endtask

  task automatic test_flush();
    logic [63:0] ld, prev;
    // flush in IDLE suppresses capture
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h5000; req_funct3 = F3_D; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (state_dbg !== IDLE || bus.req_valid !== 1'b0)
      begin failures++; $display("FAIL flush_idle: state=%0d valid=%b want IDLE 0", state_dbg, bus.req_valid); end
    req_valid = 1'b0;
    step();
    do_access(1'b0, 64'h5000, 64'd0, F3_D, 0, 0, 64'h0123_4567_89AB_CDEF, ld);
    prev = 64'h0123_4567_89AB_CDEF;
    // flush while waiting for the response
    req_valid = 1'b1; req_addr = 64'h5010; req_funct3 = F3_D;
    step();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL drain_ready: got %b want 1", mem_ready); end
    req_addr = 64'h5018;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL drain_block: valid=%b want 0", bus.req_valid); end
    end
    bus.resp_valid = 1'b1; bus.resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    bus.resp_valid = 1'b0;
    checks++;
    if (load_data !== prev) begin failures++; $display("FAIL drain_no_update: got %h want %h", load_data, prev); end
    checks++;
    if (state_dbg !== IDLE) begin failures++; $display("FAIL drain_exit: state=%0d want IDLE", state_dbg); end
    do_access(1'b0, 64'h5018, 64'd0, F3_D, 0, 0, 64'h1111_2222_3333_4444, ld);
  endtask

  task automatic test_misalign();
    logic [63:0] ld;
`ifdef MEM_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h3002; req_funct3 = F3_W;
    step();
    checks++;
    if (bus.req_valid !== 1'b0 || exc_misalign !== 1'b1 || exc_store !== 1'b0 || mem_ready !== 1'b1)
      begin failures++; $display("FAIL trap_load: valid=%b exc=%b%b ready=%b want 0 10 1", bus.req_valid, exc_misalign, exc_store, mem_ready); end
    req_valid = 1'b0;
    step();
    checks++;
    if (exc_misalign !== 1'b0 || state_dbg !== IDLE)
      begin failures++; $display("FAIL trap_one_cycle: exc=%b state=%0d want 0 IDLE", exc_misalign, state_dbg); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h3001; req_funct3 = F3_H;
    step();
    checks++;
    if (bus.req_valid !== 1'b0 || exc_misalign !== 1'b1 || exc_store !== 1'b1)
      begin failures++; $display("FAIL trap_store: valid=%b exc=%b%b want 0 11", bus.req_valid, exc_misalign, exc_store); end
    req_valid = 1'b0;
    step();
    do_access(1'b0, 64'h3004, 64'd0, F3_W, 0, 0, 64'h1234_5678_0000_0000, ld);
`else
    do_access(1'b0, 64'h3002, 64'd0, F3_W, 0, 0, 64'h0000_1234_5678_0000, ld);
`endif
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h4000; req_wdata = 64'h55; req_funct3 = F3_D;
    step();
    checks++;
    if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL rmid_req: valid=%b want 1", bus.req_valid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.req_valid !== 1'b0 || state_dbg !== IDLE)
      begin failures++; $display("FAIL rmid_async: valid=%b state=%0d want 0 IDLE", bus.req_valid, state_dbg); end
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    bus.resp_valid = 1'b1; bus.resp_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    bus.resp_valid = 1'b0;
    checks++;
    if (state_dbg !== IDLE || load_data !== 64'd0 || bus.req_valid !== 1'b0)
      begin failures++; $display("FAIL rmid_release: state=%0d ld=%h valid=%b want IDLE 0 0", state_dbg, load_data, bus.req_valid); end
  endtask

  task automatic test_random();
    logic [63:0] ld, addr;
    logic [2:0]  f3;
    logic        wr;
    int bytes;
    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      f3    = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      bytes = 1 << f3[1:0];
      addr  = {$urandom, $urandom};
      addr  = addr & ~(64'(bytes) - 64'd1);
      do_access(wr, addr, {$urandom, $urandom}, f3, $urandom_range(0, 3), $urandom_range(0, 3),
                {$urandom, $urandom}, ld);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    test_reset();
    test_store();
    test_load_extend();
    test_stall();
    test_flush();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
